// File: rtl/fpu_flip_sched_if.sv
// Requester/issue/credit-return bundle between the FPU issue scheduler and its environment.
interface fpu_flip_sched_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_vld;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_grant;
  logic                  out_vld;
  logic [WIDTH-1:0]      out_data;
  logic [IW-1:0]         out_src;
  logic                  out_stall;
  logic                  ret_vld;
  logic [IW-1:0]         ret_src;
  logic                  credit_err;

  modport master (
    input  req_vld, req_data, out_stall, ret_vld, ret_src,
    output req_grant, out_vld, out_data, out_src, credit_err
  );

  modport slave (
    output req_vld, req_data, out_stall, ret_vld, ret_src,
    input  req_grant, out_vld, out_data, out_src, credit_err
  );
endinterface

// File: rtl/fpu_flip_sched.sv
// Credit-based round-robin scheduler feeding one FPU issue register from NREQ requester buffers.
// Optional macro FPU_FLIP_SCHED_PRIO_EN gives requester 0 strict priority over the round-robin group.
module fpu_flip_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CREDITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  fpu_flip_sched_if.master bus
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [CW-1:0]    credit_q [NREQ];
  logic [CW-1:0]    credit_d [NREQ];
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IW-1:0]    out_src_q, out_src_d;
  logic             err_q, err_d;
  logic             init_q;

  logic [NREQ-1:0]  elig_c;
  logic [NREQ-1:0]  grant_c;
  logic [IW-1:0]    win_c;
  logic             found_c;
  logic             accept_c;

  // Lowest eligible index at or above base, otherwise lowest eligible overall; MSB flags a hit.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] elig, input logic [IW-1:0] base);
    logic          hit;
    logic [IW-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!hit && elig[k] && (IW'(k) >= base)) begin
        hit = 1'b1;
        idx = IW'(k);
      end
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!hit && elig[k]) begin
        hit = 1'b1;
        idx = IW'(k);
      end
    end
    return {hit, idx};
  endfunction

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    credit_d   = credit_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    err_d      = err_q;
    grant_c    = '0;
    elig_c     = '0;
    win_c      = '0;
    found_c    = 1'b0;
    accept_c   = !out_vld_q || !bus.out_stall;

    for (int unsigned k = 0; k < NREQ; k++) begin
      elig_c[k] = bus.req_vld[k] && (credit_q[k] != '0);
    end

`ifdef FPU_FLIP_SCHED_PRIO_EN
    if (elig_c[0]) begin
      found_c = 1'b1;
      win_c   = '0;
    end else begin
      {found_c, win_c} = rr_pick(elig_c & ~NREQ'(1), (rr_q == '0) ? IW'(1) : rr_q);
    end
`else
    {found_c, win_c} = rr_pick(elig_c, rr_q);
`endif

    // Grants are suppressed in reset and in the first cycle after it (init_q still low).
    if (rst && init_q && accept_c && found_c) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (IW'(k) == win_c) begin
          grant_c[k] = 1'b1;
          out_data_d = bus.req_data[k*WIDTH +: WIDTH];
        end
      end
      out_vld_d = 1'b1;
      out_src_d = win_c;
      state_d   = ISSUE;
`ifdef FPU_FLIP_SCHED_PRIO_EN
      if (win_c != '0) begin
        rr_d = (win_c == IW'(NREQ-1)) ? '0 : win_c + IW'(1);
      end
`else
      rr_d = (win_c == IW'(NREQ-1)) ? '0 : win_c + IW'(1);
`endif
    end else if (accept_c) begin
      out_vld_d = 1'b0;
      state_d   = IDLE;
    end else begin
      state_d = HOLD;
    end

    // A grant and a return on the same requester cancel out.
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant_c[k] && !(bus.ret_vld && (bus.ret_src == IW'(k)))) begin
        credit_d[k] = credit_q[k] - CW'(1);
      end else if (!grant_c[k] && bus.ret_vld && (bus.ret_src == IW'(k))) begin
        if (credit_q[k] == CRED_MAX) begin
          err_d = 1'b1;
        end else begin
          credit_d[k] = credit_q[k] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_src_q  <= '0;
      err_q      <= 1'b0;
      init_q     <= 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
        credit_q[k] <= CRED_MAX;
      end
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      err_q      <= err_d;
      init_q     <= 1'b1;
      for (int unsigned k = 0; k < NREQ; k++) begin
        credit_q[k] <= credit_d[k];
      end
    end
  end

  assign bus.req_grant  = grant_c;
  assign bus.out_vld    = out_vld_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_src    = out_src_q;
  assign bus.credit_err = err_q;
endmodule

// File: tb/tb_fpu_flip_sched.sv
// Directed self-checking bench for fpu_flip_sched (NREQ=4, WIDTH=32, CREDITS=4).
module tb_fpu_flip_sched;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [31:0] d [4];

  fpu_flip_sched_if #(.NREQ(4), .WIDTH(32)) bus ();

  fpu_flip_sched #(.NREQ(4), .WIDTH(32), .CREDITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vld;
    logic       stall;
    logic       ret;
    logic [1:0] src;
    logic [3:0] g;
    logic       ov;
    logic [1:0] os;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs are applied 1 time unit after posedge and sampled 3 units later.
  task automatic drive(input logic [3:0] vld, input logic stall, input logic ret, input logic [1:0] src);
    bus.req_vld   = vld;
    bus.out_stall = stall;
    bus.ret_vld   = ret;
    bus.ret_src   = src;
    #3;
  endtask

  task automatic expect_cyc(input string tag, input logic [3:0] g, input logic ov,
                            input logic [1:0] os, input logic err);
    chk({tag, " grant"}, 64'(bus.req_grant), 64'(g));
    chk({tag, " out_vld"}, 64'(bus.out_vld), 64'(ov));
    if (ov) begin
      chk({tag, " out_src"}, 64'(bus.out_src), 64'(os));
      chk({tag, " out_data"}, 64'(bus.out_data), 64'(d[os]));
    end
    chk({tag, " credit_err"}, 64'(bus.credit_err), 64'(err));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
`ifndef FPU_FLIP_SCHED_PRIO_EN
    vec_t tbl [23];
`endif
    logic [3:0] pg [9];
    d[0] = 32'h0000_1111;
    d[1] = 32'h2222_0001;
    d[2] = 32'h3333_0002;
    d[3] = 32'hDEAD_BEEF;
    bus.req_data  = {d[3], d[2], d[1], d[0]};
    rst           = 1'b0;
    bus.req_vld   = 4'hF;
    bus.out_stall = 1'b0;
    bus.ret_vld   = 1'b0;
    bus.ret_src   = 2'd0;

    // Reset cycle: requests present but nothing may be granted.
    repeat (3) @(posedge clk);
    #4;
    chk("reset grant", 64'(bus.req_grant), 64'h0);
    chk("reset out_vld", 64'(bus.out_vld), 64'h0);
    chk("reset out_data", 64'(bus.out_data), 64'h0);
    chk("reset out_src", 64'(bus.out_src), 64'h0);
    chk("reset credit_err", 64'(bus.credit_err), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

`ifndef FPU_FLIP_SCHED_PRIO_EN
    //          vld   stl ret src  grant ov  os
    tbl[0]  = '{4'hF, 0, 0, 2'd0, 4'h0, 0, 2'd0};
    tbl[1]  = '{4'hF, 0, 0, 2'd0, 4'h1, 0, 2'd0};
    tbl[2]  = '{4'hF, 0, 0, 2'd0, 4'h2, 1, 2'd0};
    tbl[3]  = '{4'hF, 0, 0, 2'd0, 4'h4, 1, 2'd1};
    tbl[4]  = '{4'hF, 0, 0, 2'd0, 4'h8, 1, 2'd2};
    tbl[5]  = '{4'hF, 0, 0, 2'd0, 4'h1, 1, 2'd3};
    tbl[6]  = '{4'h0, 0, 0, 2'd0, 4'h0, 1, 2'd0};
    tbl[7]  = '{4'h0, 0, 0, 2'd0, 4'h0, 0, 2'd0};
    tbl[8]  = '{4'h0, 0, 1, 2'd0, 4'h0, 0, 2'd0};
    tbl[9]  = '{4'h0, 0, 1, 2'd0, 4'h0, 0, 2'd0};
    tbl[10] = '{4'h0, 0, 1, 2'd1, 4'h0, 0, 2'd0};
    tbl[11] = '{4'h0, 0, 1, 2'd2, 4'h0, 0, 2'd0};
    tbl[12] = '{4'h0, 0, 1, 2'd3, 4'h0, 0, 2'd0};
    tbl[13] = '{4'h4, 0, 0, 2'd0, 4'h4, 0, 2'd0};
    tbl[14] = '{4'h4, 0, 0, 2'd0, 4'h4, 1, 2'd2};
    tbl[15] = '{4'h4, 0, 0, 2'd0, 4'h4, 1, 2'd2};
    tbl[16] = '{4'h4, 0, 0, 2'd0, 4'h4, 1, 2'd2};
    tbl[17] = '{4'h4, 0, 0, 2'd0, 4'h0, 1, 2'd2};
    tbl[18] = '{4'h4, 0, 0, 2'd0, 4'h0, 0, 2'd0};
    tbl[19] = '{4'h4, 0, 1, 2'd2, 4'h0, 0, 2'd0};
    tbl[20] = '{4'h4, 0, 0, 2'd0, 4'h4, 0, 2'd0};
    tbl[21] = '{4'h4, 0, 0, 2'd0, 4'h0, 1, 2'd2};
    tbl[22] = '{4'h0, 0, 0, 2'd0, 4'h0, 0, 2'd0};

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].vld, tbl[i].stall, tbl[i].ret, tbl[i].src);
      expect_cyc($sformatf("row%0d", i), tbl[i].g, tbl[i].ov, tbl[i].os, 1'b0);
    end

    // Stall of a held 0xDEADBEEF word for three cycles, then release.
    drive(4'h8, 0, 0, 2'd0); expect_cyc("a0", 4'h8, 0, 2'd0, 0);
    for (int i = 1; i <= 3; i++) begin
      drive(4'h3, 1, 0, 2'd0); expect_cyc($sformatf("hold%0d", i), 4'h0, 1, 2'd3, 0);
    end
    drive(4'h3, 0, 0, 2'd0); expect_cyc("release", 4'h1, 1, 2'd3, 0);
    drive(4'h0, 0, 0, 2'd0); expect_cyc("after_release", 4'h0, 1, 2'd0, 0);

    // Reset asserted while a word is held.
    drive(4'h2, 0, 0, 2'd0); expect_cyc("b0", 4'h2, 0, 2'd0, 0);
    drive(4'h0, 1, 0, 2'd0); expect_cyc("b1", 4'h0, 1, 2'd1, 0);
    rst = 1'b0;
    drive(4'hF, 1, 0, 2'd0); expect_cyc("b_rst", 4'h0, 1, 2'd1, 0);
    rst = 1'b1;
    drive(4'hF, 0, 0, 2'd0);
    chk("b_post out_data", 64'(bus.out_data), 64'h0);
    chk("b_post out_src", 64'(bus.out_src), 64'h0);
    expect_cyc("b_post", 4'h0, 0, 2'd0, 0);
    drive(4'hF, 0, 0, 2'd0); expect_cyc("b_rr0", 4'h1, 0, 2'd0, 0);
    drive(4'h0, 0, 0, 2'd0); expect_cyc("b_out0", 4'h0, 1, 2'd0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(4'h4, 0, 0, 2'd0); expect_cyc($sformatf("b_cred%0d", i), 4'h4, (i > 0), 2'd2, 0);
    end
    drive(4'h4, 0, 0, 2'd0); expect_cyc("b_cred_empty", 4'h0, 1, 2'd2, 0);

    // Credit overflow error is sticky until reset.
    drive(4'h0, 0, 1, 2'd1); expect_cyc("c0", 4'h0, 0, 2'd0, 0);
    for (int i = 1; i <= 3; i++) begin
      drive(4'h0, 0, 0, 2'd0); expect_cyc($sformatf("c%0d", i), 4'h0, 0, 2'd0, 1);
    end
    rst = 1'b0;
    drive(4'h0, 0, 0, 2'd0); expect_cyc("c_rst", 4'h0, 0, 2'd0, 1);
    rst = 1'b1;
    drive(4'h0, 0, 0, 2'd0); expect_cyc("c_clear", 4'h0, 0, 2'd0, 0);
`else
    // Requester 0 drains its credits first, then 1..3 rotate.
    pg[0] = 4'h0; pg[1] = 4'h1; pg[2] = 4'h1; pg[3] = 4'h1; pg[4] = 4'h1;
    pg[5] = 4'h2; pg[6] = 4'h4; pg[7] = 4'h8; pg[8] = 4'h2;
    for (int i = 0; i < 9; i++) begin
      logic [1:0] os;
      os = (i >= 2 && i <= 5) ? 2'd0 : (i == 6) ? 2'd1 : (i == 7) ? 2'd2 : 2'd3;
      drive(4'hF, 0, 0, 2'd0);
      expect_cyc($sformatf("prio%0d", i), pg[i], (i >= 2), os, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
